// File: rtl/spi_slave_if.sv
// Bus bundle between an SPI mode-3 slave and its host: TX/RX byte handshake plus the SPI wire pins.
interface spi_slave_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       tx_underrun;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       miso;

  modport slave (
    input  tx_valid, tx_data, sclk, mosi, cs_n,
    output tx_ready, rx_valid, rx_data, busy, tx_underrun, miso
  );

  modport master (
    output tx_valid, tx_data, sclk, mosi, cs_n,
    input  tx_ready, rx_valid, rx_data, busy, tx_underrun, miso
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-3 (CPOL=1, CPHA=1, MSB first) slave, oversampled by clk, with a one-entry TX buffer.
module spi_slave #(
  parameter logic [7:0] DEFAULT_TX  = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst_n,
  spi_slave_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_rise;
  logic                   cs_fall;
  logic [2:0]             bit_cnt;
  logic [7:0]             tx_shift;
  logic [7:0]             rx_shift;
  logic [7:0]             tx_buf;
  logic                   buf_empty;
  logic                   miso_r;
  logic                   rx_valid_r;
  logic [7:0]             rx_data_r;
  logic                   busy_r;
  logic                   underrun_r;

  // Idle-high lines reset to 1 so a reset never fabricates an edge on sclk or cs_n.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b1;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      tx_shift   <= 8'h00;
      rx_shift   <= 8'h00;
      tx_buf     <= 8'h00;
      buf_empty  <= 1'b1;
      miso_r     <= 1'b1;
      rx_valid_r <= 1'b0;
      rx_data_r  <= 8'h00;
      busy_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      underrun_r <= 1'b0;
      case (state)
        IDLE: begin
          miso_r <= 1'b1;
          if (cs_fall) begin
            state    <= ACTIVE;
            busy_r   <= 1'b1;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state   <= IDLE;
            busy_r  <= 1'b0;
            bit_cnt <= 3'd0;
            miso_r  <= 1'b1;
          end else begin
            if (sclk_fall) begin
              if (bit_cnt == 3'd0) begin
                // Load sees the buffer as it was before this edge: no same-cycle bypass.
                if (!buf_empty) begin
                  tx_shift  <= tx_buf;
                  miso_r    <= tx_buf[7];
                  buf_empty <= 1'b1;
                end else begin
                  tx_shift   <= DEFAULT_TX;
                  miso_r     <= DEFAULT_TX[7];
                  underrun_r <= 1'b1;
                end
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                miso_r   <= tx_shift[6];
              end
            end
            if (sclk_rise) begin
              rx_shift <= {rx_shift[6:0], mosi_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data_r  <= {rx_shift[6:0], mosi_s};
                rx_valid_r <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Capture only happens while empty, so it never collides with the load above.
      if (bus.tx_valid && buf_empty) begin
        tx_buf    <= bus.tx_data;
        buf_empty <= 1'b0;
      end
    end
  end

  assign bus.tx_ready    = buf_empty;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.rx_data     = rx_data_r;
  assign bus.busy        = busy_r;
  assign bus.tx_underrun = underrun_r;
  assign bus.miso        = miso_r;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives mode-3 frames as SPI master and scoreboards MISO and RX bytes.
module tb_spi_slave;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 16;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   exp_und = 0;
  int   und_cnt = 0;
  int   rx_rd = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] got_rx[$];

  spi_slave_if bus ();

  spi_slave #(.DEFAULT_TX(8'hFF), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records what the DUT produces; comparisons happen in the main sequence.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) got_rx.push_back(bus.rx_data);
    if (bus.tx_underrun === 1'b1) und_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, {7'd0, bus.miso}, 8'h01);
    check({tag, "_tx_ready"}, {7'd0, bus.tx_ready}, 8'h01);
    check({tag, "_rx_valid"}, {7'd0, bus.rx_valid}, 8'h00);
    check({tag, "_rx_data"}, bus.rx_data, 8'h00);
    check({tag, "_busy"}, {7'd0, bus.busy}, 8'h00);
    check({tag, "_underrun"}, {7'd0, bus.tx_underrun}, 8'h00);
  endtask

  task automatic check_rx(input string tag);
    while (exp_rx.size() > 0) begin
      logic [7:0] e;
      e = exp_rx.pop_front();
      check({tag, "_rx_present"}, 8'(got_rx.size() > rx_rd), 8'h01);
      if (got_rx.size() > rx_rd) begin
        check({tag, "_rx_data"}, got_rx[rx_rd], e);
        rx_rd++;
      end
    end
    check({tag, "_rx_extra"}, 8'(got_rx.size() - rx_rd), 8'h00);
  endtask

  task automatic check_und(input string tag);
    check({tag, "_underruns"}, 8'(und_cnt), 8'(exp_und));
  endtask

  task automatic offer(input logic [7:0] d, input string tag);
    for (int i = 0; i < 2000 && bus.tx_ready !== 1'b1; i++) @(negedge clk);
    check({tag, "_ready"}, {7'd0, bus.tx_ready}, 8'h01);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check({tag, "_taken"}, {7'd0, bus.tx_ready}, 8'h00);
  endtask

  task automatic cs_low();
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    bus.cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // One full byte; optionally offers inj_data exactly on the clk edge where the byte load happens.
  task automatic spi_byte(input logic [7:0] mval, input logic [7:0] exp_m, input string tag,
                          input logic inject, input logic [7:0] inj_data);
    logic [7:0] got;
    exp_rx.push_back(mval);
    exp_tx.push_back(exp_m);
    got = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      bus.sclk = 1'b0;
      bus.mosi = mval[i];
      if (inject && i == 7) begin
        repeat (SYNC_STAGES) @(negedge clk);
        bus.tx_data  = inj_data;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check({tag, "_inj_taken"}, {7'd0, bus.tx_ready}, 8'h00);
        repeat (HALF - SYNC_STAGES - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      got[i]   = bus.miso;
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    check({tag, "_miso"}, got, exp_tx.pop_front());
  endtask

  task automatic spi_bits(input logic [7:0] mval, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bus.sclk = 1'b0;
      bus.mosi = mval[i];
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.cs_n     = 1'b1;
    bus.sclk     = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // SCLK/MOSI activity with cs_n high must be ignored.
    bus.mosi = 1'b1;
    repeat (4) begin
      bus.sclk = ~bus.sclk;
      repeat (HALF) @(negedge clk);
    end
    check("idle_miso", {7'd0, bus.miso}, 8'h01);
    check("idle_busy", {7'd0, bus.busy}, 8'h00);
    check_rx("idle");
    check_und("idle");

    $display("[TB] buffered A5, master sends 3C");
    offer(8'hA5, "t35");
    cs_low();
    check("t35_busy", {7'd0, bus.busy}, 8'h01);
    spi_byte(8'h3C, 8'hA5, "t35", 1'b0, 8'h00);
    cs_high();
    check("t35_busy_end", {7'd0, bus.busy}, 8'h00);
    check_rx("t35");
    check_und("t35");

    $display("[TB] empty buffer, master sends 00");
    cs_low();
    spi_byte(8'h00, 8'hFF, "t36", 1'b0, 8'h00);
    cs_high();
    exp_und++;
    check_rx("t36");
    check_und("t36");

    $display("[TB] two-byte frame DE AD with 11 22 queued");
    offer(8'h11, "t37a");
    cs_low();
    fork
      spi_byte(8'hDE, 8'h11, "t37a", 1'b0, 8'h00);
      offer(8'h22, "t37b");
    join
    spi_byte(8'hAD, 8'h22, "t37b", 1'b0, 8'h00);
    cs_high();
    check_rx("t37");
    check_und("t37");

    $display("[TB] abort after 5 bits, then 5A");
    cs_low();
    spi_bits(8'hF0, 5);
    cs_high();
    exp_und++;
    check("t38_busy", {7'd0, bus.busy}, 8'h00);
    check_rx("t38_abort");
    cs_low();
    spi_byte(8'h5A, 8'hFF, "t38", 1'b0, 8'h00);
    cs_high();
    exp_und++;
    check_rx("t38");
    check_und("t38");

    $display("[TB] reset mid-byte with buffer refilled, then 81");
    offer(8'h99, "t39a");
    cs_low();
    spi_bits(8'hC3, 4);
    offer(8'h66, "t39b");
    rst_n    = 1'b0;
    bus.cs_n = 1'b1;
    bus.sclk = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("t39_rst");
    repeat (HALF) @(negedge clk);
    check_rx("t39_abort");
    check_und("t39_abort");
    cs_low();
    spi_byte(8'h81, 8'hFF, "t39", 1'b0, 8'h00);
    cs_high();
    exp_und++;
    check_rx("t39");
    check_und("t39");

    $display("[TB] offer 77 on the load edge of an empty buffer");
    cs_low();
    spi_byte(8'h12, 8'hFF, "t40a", 1'b1, 8'h77);
    exp_und++;
    check_und("t40a");
    spi_byte(8'h34, 8'h77, "t40b", 1'b0, 8'h00);
    cs_high();
    check_rx("t40");
    check_und("t40");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: DEFAULT_TX, 8'hFF, byte shifted out when no TX byte is buffered at byte start.
REQ-002 Parameter: SYNC_STAGES, 2, number of synchronizer flops on sclk/mosi/cs_n (legal: 2..3).
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 tx_valid  in  1  TX byte offered.
REQ-006 tx_data  in  8  TX byte, captured when tx_valid && tx_ready.
REQ-007 tx_ready  out  1  high when the one-entry TX buffer is empty.
REQ-008 rx_valid  out  1  one-cycle pulse; rx_data holds a complete received byte.
REQ-009 rx_data  out  8  last complete received byte, MSB first on wire.
REQ-010 busy  out  1  high while in ACTIVE.
REQ-011 tx_underrun  out  1  one-cycle pulse when DEFAULT_TX is loaded due to empty buffer.
REQ-012 sclk  in  1  SPI clock from master, asynchronous to clk.
REQ-013 mosi  in  1  SPI data from master, asynchronous.
REQ-014 cs_n  in  1  active-low chip select, frames the transaction.
REQ-015 miso  out  1  SPI data to master.

Function
REQ-016 SPI mode 3 SHALL be used: CPOL=1, CPHA=1, MSB first; data changes on SCLK falling edge, sampled on rising edge.
REQ-017 sclk, mosi, cs_n SHALL each pass through SYNC_STAGES flops; edges SHALL be detected by comparing the last sync stage with one further delay flop.
REQ-018 Correct operation SHALL be required only for SCLK high and low phases each >= SYNC_STAGES+2 clk cycles.
REQ-019 States SHALL be IDLE and ACTIVE; IDLE->ACTIVE on synchronized cs_n falling edge; ACTIVE->IDLE on synchronized cs_n rising edge.
REQ-020 On entering ACTIVE, bit_cnt SHALL be 0 and rx shift register SHALL be cleared.
REQ-021 On synchronized SCLK falling edge in ACTIVE with bit_cnt==0, shift register SHALL load the TX buffer (buffer then empty) or DEFAULT_TX if empty; miso SHALL present bit 7.
REQ-022 On synchronized SCLK falling edge with bit_cnt!=0, TX shift register SHALL shift left one bit; miso = shift[7].
REQ-023 On synchronized SCLK rising edge in ACTIVE, rx shift SHALL capture synchronized mosi into LSB and bit_cnt SHALL increment modulo 8.
REQ-024 On the rising edge taking bit_cnt 7->0, rx_data SHALL update with the full byte and rx_valid SHALL pulse high for exactly one cycle, both registered on the same clk edge as the last rx shift.
REQ-025 Multi-byte transfers SHALL be supported with cs_n held low; each byte boundary repeats REQ-021..024.
REQ-026 TX buffer SHALL accept when tx_valid && tx_ready; tx_ready SHALL fall the following cycle.
REQ-027 Capture and byte-load in the same cycle with empty buffer: load SHALL use DEFAULT_TX (no bypass), tx_underrun pulses, buffer SHALL capture tx_data.
REQ-028 tx_underrun SHALL pulse one cycle whenever REQ-021 loads DEFAULT_TX.
REQ-029 cs_n rising mid-byte (bit_cnt!=0): partial byte SHALL be discarded, no rx_valid, bit_cnt SHALL reset to 0; a TX byte already loaded is lost.
REQ-030 In IDLE, miso SHALL be driven 1 and SCLK/MOSI edges SHALL be ignored.
REQ-031 rx_data SHALL hold its value until the next completed byte; no back-pressure on RX.

Reset
REQ-032 When rst_n is low at a clk edge: state IDLE, bit_cnt 0, shift registers 0, TX buffer empty.
REQ-033 Reset outputs: miso 1, tx_ready 1, rx_valid 0, rx_data 8'h00, busy 0, tx_underrun 0.
REQ-034 Reset values of sclk and cs_n sync/delay flops SHALL be 1; mosi flops 0; reset mid-transfer SHALL abort without rx_valid.

Verification
REQ-035 Buffer 8'hA5, master sends 8'h3C (half-period 16 clk) -> miso bits 1,0,1,0,0,1,0,1; rx_data 8'h3C with one rx_valid pulse.
REQ-036 No byte buffered, master sends 8'h00 -> miso 8'hFF on wire, tx_underrun one pulse, rx_data 8'h00.
REQ-037 cs_n held low, buffer 8'h11 then 8'h22 on tx_ready, master sends 8'hDE,8'hAD -> miso 8'h11,8'h22; rx_valid twice with 8'hDE then 8'hAD.
REQ-038 cs_n released after 5 SCLK rising edges -> no rx_valid, busy low, next transfer of 8'h5A received correctly.
REQ-039 rst_n low for 1 cycle mid-byte -> all outputs at reset values next cycle, no rx_valid; subsequent 8'h81 transfer correct.
REQ-040 tx_valid with 8'h77 in cycle of first falling-edge load on empty buffer -> wire byte 8'hFF, tx_underrun pulse, next byte 8'h77.
